// File: rtl/bus_if_types_pkg.sv
// Shared bus handshake types plus the SRAM slave FSM states and the byte-lane helper.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  // Encoding matches the RISC-V load/store funct3[1:0]; 3 is never a legal size.
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF      = 2'd1,
    WORD      = 2'd2,
    SIZE_RSVD = 2'd3
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sram_slv_state_e;

  function automatic logic [3:0] lane_mask(tsize_e size, logic [1:0] lane);
    case (size)
      BYTE:    lane_mask = 4'b0001 << lane;
      HALF:    lane_mask = 4'b0011 << lane;
      WORD:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Word-wide single-port SRAM: synchronous read with enable, per-byte write enables.
module sram_bank #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic          rd_en,
  output logic [31:0]   q,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: neither the array nor its read register is reset; a reset would stop the
  // array mapping onto block RAM, and the slave masks q until a real read lands.
  always_ff @(posedge clk) begin
    if (rd_en) q <= mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// bstart/bdone responder in front of a word-organised SRAM with wait states and lane steering.
// Define BUS_SRAM_SLAVE_BERR_EN to add the berr output and the bstart protocol assertion.
module bus_sram_slave
  import bus_if_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        breq,
  input  logic        bstart,
  input  ttype_e      ttype,
  input  tsize_e      tsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone
`ifdef BUS_SRAM_SLAVE_BERR_EN
  ,
  output logic        berr
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef struct packed {
    ttype_e        ttype;
    tsize_e        tsize;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          err;
  } req_t;

  sram_slv_state_e state, state_next;
  logic [3:0]      cnt, cnt_next;
  req_t            live, req_q;
  logic [32:0]     diff;
  logic            accept;

  // Bit 32 of the widened difference is the borrow, i.e. addr below BASE_ADDR.
  assign diff = {1'b0, addr} - {1'b0, BASE_ADDR};

  always_comb begin
    live.ttype = ttype;
    live.tsize = tsize;
    live.lane  = addr[1:0];
    live.idx   = diff[AW+1:2];
    live.wdata = wdata;
    live.err   = diff[32] || ({1'b0, diff[31:0]} >= SPAN);
    case (tsize)
      BYTE:    ;
      HALF:    if (addr[0]) live.err = 1'b1;
      WORD:    if (addr[1:0] != 2'b00) live.err = 1'b1;
      default: live.err = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && breq && bstart;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With no wait states the RAM read happens on the acceptance edge itself, so the
  // read path looks at the live request while IDLE and the captured one afterwards.
  logic          cur_read, cur_err;
  logic [1:0]    cur_lane;
  tsize_e        cur_size;
  logic [AW-1:0] cur_idx;
  logic          rd_load;

  assign cur_read = (state == IDLE) ? (live.ttype == READ) : (req_q.ttype == READ);
  assign cur_err  = (state == IDLE) ? live.err   : req_q.err;
  assign cur_lane = (state == IDLE) ? live.lane  : req_q.lane;
  assign cur_size = (state == IDLE) ? live.tsize : req_q.tsize;
  assign cur_idx  = (state == IDLE) ? live.idx   : req_q.idx;
  assign rd_load  = (state_next == RESP) && cur_read;

  logic       rd_zero;
  logic [1:0] rd_lane;
  tsize_e     rd_size;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rd_zero <= 1'b1;
      rd_lane <= 2'b00;
      rd_size <= BYTE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (rd_load) begin
        rd_zero <= cur_err;
        rd_lane <= cur_lane;
        rd_size <= cur_size;
      end
    end
  end

  // Captured request is pure datapath, only ever consumed once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if (accept) req_q <= live;
  end

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_word;

  always_comb begin
    wr_be = 4'b0000;
    if ((state == RESP) && (req_q.ttype == WRITE) && !req_q.err && rst_n)
      wr_be = lane_mask(req_q.tsize, req_q.lane);
    case (req_q.tsize)
      BYTE:    wr_data = {4{req_q.wdata[7:0]}};
      HALF:    wr_data = {2{req_q.wdata[15:0]}};
      default: wr_data = req_q.wdata;
    endcase
  end

  sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_bank (
    .clk     (clk),
    .idx     (cur_idx),
    .rd_en   (rd_load && !cur_err),
    .q       (rd_word),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  // The RAM output only moves on reads, so this stays put through write responses.
  logic [31:0] shifted;

  always_comb begin
    shifted = rd_word >> {rd_lane, 3'b000};
    case (rd_size)
      BYTE:    rdata = {24'h0, shifted[7:0]};
      HALF:    rdata = {16'h0, shifted[15:0]};
      default: rdata = shifted;
    endcase
    if (rd_zero) rdata = 32'h0;
  end

  assign bdone = (state == RESP);

`ifdef BUS_SRAM_SLAVE_BERR_EN
  assign berr = (state == RESP) && req_q.err;

`ifndef SYNTHESIS
  bstart_rise_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) $rose(bstart) |-> (state == IDLE)
  ) else $error("bstart rose while a transaction was in flight");
`endif
`endif

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: three instances (0, 3 and 2 wait states) against a byte-level model.
`timescale 1ns/1ps
module tb_bus_sram_slave;
  import bus_if_types_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
  localparam int          NB    = 4 * DEPTH;
  localparam int          NDUT  = 3;

  function automatic int ws_of(int i);
    return (i == 1) ? 3 : ((i == 2) ? 2 : 0);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n   [NDUT];
  logic        breq    [NDUT];
  logic        bstart  [NDUT];
  ttype_e      ttype_s [NDUT];
  tsize_e      tsize_s [NDUT];
  logic [31:0] addr_s  [NDUT];
  logic [31:0] wdata_s [NDUT];
  logic [31:0] rdata_s [NDUT];
  logic        bdone_s [NDUT];
`ifdef BUS_SRAM_SLAVE_BERR_EN
  logic        berr_s  [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bus_sram_slave #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (ws_of(g)),
      .INIT_FILE   ("")
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n[g]),
      .breq   (breq[g]),
      .bstart (bstart[g]),
      .ttype  (ttype_s[g]),
      .tsize  (tsize_s[g]),
      .addr   (addr_s[g]),
      .wdata  (wdata_s[g]),
      .rdata  (rdata_s[g]),
      .bdone  (bdone_s[g])
`ifdef BUS_SRAM_SLAVE_BERR_EN
      ,
      .berr   (berr_s[g])
`endif
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: byte-addressed memory, one request at a time
  logic [7:0]  mmem      [NDUT][NB];
  bit          m_busy    [NDUT];
  int          m_left    [NDUT];
  bit          m_write   [NDUT];
  bit          m_err     [NDUT];
  int          m_off     [NDUT];
  int          m_nb      [NDUT];
  logic [31:0] m_wdata   [NDUT];
  logic [31:0] m_pend    [NDUT];
  logic [31:0] exp_rdata [NDUT];
  bit          exp_bdone [NDUT];
  bit          exp_berr  [NDUT];

  function automatic int size_bytes(tsize_e s);
    case (s)
      BYTE:    return 1;
      HALF:    return 2;
      WORD:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_err(logic [31:0] a, tsize_e s);
    longint o = longint'(a) - longint'(BASE);
    if (o < 0 || o >= NB) return 1'b1;
    if (s == SIZE_RSVD) return 1'b1;
    if ((a % 32'(size_bytes(s))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] read_model(int i, int off, int nb);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mmem[i][off + k];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst_n[i] !== 1'b1) begin
        m_busy[i]    = 1'b0;
        exp_rdata[i] = 32'h0;
      end else if (m_busy[i]) begin
        if (m_left[i] == 0) begin
          if (m_write[i] && !m_err[i])
            for (int k = 0; k < m_nb[i]; k++) mmem[i][m_off[i] + k] = m_wdata[i][8*k +: 8];
          m_busy[i] = 1'b0;
        end else begin
          m_left[i]--;
          if (m_left[i] == 0 && !m_write[i]) exp_rdata[i] = m_pend[i];
        end
      end else if (breq[i] && bstart[i]) begin
        m_busy[i]  = 1'b1;
        m_left[i]  = ws_of(i);
        m_write[i] = (ttype_s[i] == WRITE);
        m_err[i]   = is_err(addr_s[i], tsize_s[i]);
        m_off[i]   = int'(addr_s[i] - BASE);
        m_nb[i]    = size_bytes(tsize_s[i]);
        m_wdata[i] = wdata_s[i];
        if (!m_write[i]) begin
          m_pend[i] = m_err[i] ? 32'h0 : read_model(i, m_off[i], m_nb[i]);
          if (m_left[i] == 0) exp_rdata[i] = m_pend[i];
        end
      end
      exp_bdone[i] = m_busy[i] && (m_left[i] == 0);
      exp_berr[i]  = exp_bdone[i] && m_err[i];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("dut%0d bdone", i), 32'(bdone_s[i]), 32'(exp_bdone[i]));
        check($sformatf("dut%0d rdata", i), rdata_s[i], exp_rdata[i]);
`ifdef BUS_SRAM_SLAVE_BERR_EN
        check($sformatf("dut%0d berr", i), 32'(berr_s[i]), 32'(exp_berr[i]));
`endif
      end
    end
  end

  // ---------------- stimulus
  task automatic xact(input int i, input ttype_e t, input tsize_e s, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int lat = 0;
    @(negedge clk);
    breq[i] = 1'b1; bstart[i] = 1'b1;
    ttype_s[i] = t; tsize_s[i] = s; addr_s[i] = a; wdata_s[i] = wd;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bdone_s[i] === 1'b1) begin
        lat = c;
        break;
      end
      // Request fields must be ignored once accepted.
      addr_s[i]  = $urandom;
      wdata_s[i] = $urandom;
      ttype_s[i] = ttype_e'($urandom_range(0, 1));
      tsize_s[i] = tsize_e'($urandom_range(0, 3));
    end
    rd = rdata_s[i];
    er = 1'b0;
`ifdef BUS_SRAM_SLAVE_BERR_EN
    er = berr_s[i];
`endif
    breq[i] = 1'b0; bstart[i] = 1'b0;
    check($sformatf("dut%0d latency", i), 32'(lat), 32'(ws_of(i) + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < NDUT; i++) begin
      rst_n[i] = 1'b0; breq[i] = 1'b0; bstart[i] = 1'b0;
      ttype_s[i] = READ; tsize_s[i] = WORD; addr_s[i] = BASE; wdata_s[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d reset bdone", i), 32'(bdone_s[i]), 32'h0);
      check($sformatf("dut%0d reset rdata", i), rdata_s[i], 32'h0);
      rst_n[i] = 1'b1;
    end
    chk_on = 1'b1;

    // Fill every word so all later reads have defined contents.
    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < DEPTH; w++)
        xact(i, WRITE, WORD, BASE + 32'(4 * w), 32'hC0DE_0000 | 32'(w), rd, er);

    // Directed, zero wait states.
    xact(0, WRITE, WORD, BASE + 8, 32'hDEAD_BEEF, rd, er);
    xact(0, READ,  WORD, BASE + 8, 32'h0, rd, er);
    check("word read back", rd, 32'hDEAD_BEEF);
    xact(0, WRITE, BYTE, BASE + 9, 32'h0000_00A5, rd, er);
    xact(0, READ,  WORD, BASE + 8, 32'h0, rd, er);
    check("byte merge", rd, 32'hDEAD_A5EF);
    xact(0, READ,  BYTE, BASE + 11, 32'h0, rd, er);
    check("byte lane 3", rd, 32'h0000_00DE);
    xact(0, READ,  HALF, BASE + 10, 32'h0, rd, er);
    check("half upper", rd, 32'h0000_DEAD);

    // Errors: misaligned half write, reads outside the window and with a bad size.
    xact(0, WRITE, HALF, BASE + 1, 32'h0000_FFFF, rd, er);
`ifdef BUS_SRAM_SLAVE_BERR_EN
    check("berr misaligned write", 32'(er), 32'h1);
`endif
    xact(0, READ, WORD, BASE, 32'h0, rd, er);
    check("no write on error", rd, 32'hC0DE_0000);
`ifdef BUS_SRAM_SLAVE_BERR_EN
    check("berr clean read", 32'(er), 32'h0);
`endif
    xact(0, READ, WORD, BASE + 32'(NB), 32'h0, rd, er);
    check("read past end", rd, 32'h0);
`ifdef BUS_SRAM_SLAVE_BERR_EN
    check("berr read past end", 32'(er), 32'h1);
`endif
    xact(0, READ, BYTE, BASE - 1, 32'h0, rd, er);
    check("read below base", rd, 32'h0);
    xact(0, READ, SIZE_RSVD, BASE + 4, 32'h0, rd, er);
    check("reserved size", rd, 32'h0);

    // bstart without breq is never accepted.
    @(negedge clk);
    breq[0] = 1'b0; bstart[0] = 1'b1; ttype_s[0] = READ; tsize_s[0] = WORD; addr_s[0] = BASE + 8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no accept without breq", 32'(bdone_s[0]), 32'h0);
    end
    breq[0] = 1'b1;
    @(negedge clk);
    check("accept on breq", 32'(bdone_s[0]), 32'h1);
    check("accept on breq data", rdata_s[0], 32'hDEAD_A5EF);
    breq[0] = 1'b0; bstart[0] = 1'b0;

    // Three wait states, bstart held high: responses in cycles 4, 9 and 14.
    @(negedge clk);
    breq[1] = 1'b1; bstart[1] = 1'b1; ttype_s[1] = READ; tsize_s[1] = WORD; addr_s[1] = BASE + 8;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check($sformatf("held bstart cycle %0d", c), 32'(bdone_s[1]),
            32'((c == 4) || (c == 9) || (c == 14)));
      if (bdone_s[1] === 1'b1) check("held bstart data", rdata_s[1], 32'hC0DE_0002);
      if (c == 14) begin
        breq[1] = 1'b0; bstart[1] = 1'b0;
      end
    end

    // Two wait states, reset during WAIT drops the write.
    xact(2, READ, WORD, BASE + 4, 32'h0, rd, er);
    check("pre-reset read", rd, 32'hC0DE_0001);
    @(negedge clk);
    breq[2] = 1'b1; bstart[2] = 1'b1; ttype_s[2] = WRITE; tsize_s[2] = WORD;
    addr_s[2] = BASE; wdata_s[2] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0; breq[2] = 1'b0; bstart[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    check("bdone after mid reset", 32'(bdone_s[2]), 32'h0);
    check("rdata after mid reset", rdata_s[2], 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no bdone after mid reset", 32'(bdone_s[2]), 32'h0);
    end
    xact(2, READ, WORD, BASE, 32'h0, rd, er);
    check("write dropped by reset", rd, 32'hC0DE_0000);

    // Randomised traffic on every instance, checked cycle by cycle against the model.
    for (int i = 0; i < NDUT; i++) begin
      for (int n = 0; n < 150; n++) begin
        ttype_e      t = ttype_e'($urandom_range(0, 1));
        tsize_e      s = ($urandom_range(0, 9) == 0) ? SIZE_RSVD : tsize_e'($urandom_range(0, 2));
        int          r = $urandom_range(0, 9);
        logic [31:0] a;
        if (r < 8) begin
          a = BASE + 32'($urandom_range(0, NB - 1));
          if (r < 6 && s != SIZE_RSVD) a = a & ~32'(size_bytes(s) - 1);
        end else if (r == 8) begin
          a = BASE - 32'($urandom_range(1, 16));
        end else begin
          a = BASE + 32'(NB) + 32'($urandom_range(0, 15));
        end
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          breq[i] = 1'b0; bstart[i] = 1'($urandom_range(0, 1));
        end
        xact(i, t, s, a, $urandom, rd, er);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
